ftq: RTL and testbench

FTQ -- requirements
Module: ftq

---
 rtl/ftq_pkg.sv | 97 +++++++++
 rtl/ftq_update_gen.sv | 35 +++
 rtl/ftq.sv | 99 +++++++++
 tb/tb_ftq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftq_pkg.sv
// Frontend configuration shared by the fetch target queue: address widths, FTQ
// entry and FTB training formats, and the FTB helper functions (ftbFuncs).
package ftq_pkg;

  localparam int XLEN               = 32;
  localparam int FTQ_SIZE_DEF       = 16;
  localparam int FTQ_IDX_W          = $clog2(FTQ_SIZE_DEF);
  localparam int FTB_FALLTHRU_WIDTH = 5;
  localparam int FTB_TARGET_WIDTH   = 12;
  localparam int FT_HI_W            = XLEN - FTB_FALLTHRU_WIDTH - 1;
  localparam int TG_HI_W            = XLEN - FTB_TARGET_WIDTH - 1;

  // Index bits plus a wrap bit in the MSB.
  typedef logic [FTQ_IDX_W:0] ftqIdx_t;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_COND,
    BR_JUMP,
    BR_RET
  } branch_t;

  typedef enum logic [1:0] {
    TAR_FIT,
    TAR_OVF,
    TAR_UDF
  } tarStat_t;

  typedef struct packed {
    branch_t    branch_type;
    logic [1:0] ftb_counter;
  } ftbMeta_t;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    logic [XLEN-1:0] endAddr;
    ftbMeta_t        meta;
  } ftqInfo_t;

  typedef struct packed {
    logic [XLEN-1:0]               startAddr;
    logic [FTB_FALLTHRU_WIDTH-1:0] fallthruAddr;
    logic                          carry;
    logic [FTB_TARGET_WIDTH-1:0]   targetAddr;
    tarStat_t                      tarStat;
    branch_t                       branch_type;
    logic [1:0]                    counter;
  } BPupdateInfo_t;

  // Rebuilds a full target from the compressed FTB form relative to pc.
  function automatic logic [XLEN-1:0] calcTargetAddr(
    input logic [XLEN-1:0]             pc,
    input logic [FTB_TARGET_WIDTH-1:0] tgt,
    input tarStat_t                    stat
  );
    logic [TG_HI_W-1:0] hi;
    hi = pc[XLEN-1:FTB_TARGET_WIDTH+1];
    case (stat)
      TAR_OVF: hi = hi + TG_HI_W'(1);
      TAR_UDF: hi = hi - TG_HI_W'(1);
      default: ;
    endcase
    return {hi, tgt, 1'b0};
  endfunction

  function automatic logic [1:0] satCounter(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

  function automatic tarStat_t calcTarStat(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] target);
    logic [TG_HI_W-1:0] s_hi;
    logic [TG_HI_W-1:0] t_hi;
    s_hi = pc[XLEN-1:FTB_TARGET_WIDTH+1];
    t_hi = target[XLEN-1:FTB_TARGET_WIDTH+1];
    if (t_hi == s_hi + TG_HI_W'(1)) return TAR_OVF;
    if (t_hi == s_hi - TG_HI_W'(1)) return TAR_UDF;
    return TAR_FIT;
  endfunction

  function automatic BPupdateInfo_t calcUpdateInfo(
    input ftqInfo_t        en,
    input logic            taken,
    input logic [XLEN-1:0] target
  );
    BPupdateInfo_t u;
    u.startAddr    = en.startAddr;
    u.fallthruAddr = en.endAddr[FTB_FALLTHRU_WIDTH:1];
    u.carry        = en.endAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1] != en.startAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1];
    u.targetAddr   = target[FTB_TARGET_WIDTH:1];
    u.tarStat      = calcTarStat(en.startAddr, target);
    u.branch_type  = en.meta.branch_type;
    u.counter      = satCounter(en.meta.ftb_counter, taken);
    return u;
  endfunction

endpackage

// File: rtl/ftq_update_gen.sv
// Builds the FTB training record for the committing entry and decides whether
// the block is encodable (target within one H-step, fallthru within one carry).
module ftq_update_gen
  import ftq_pkg::*;
(
  input  ftqInfo_t        entry,
  input  logic            taken,
  input  logic [XLEN-1:0] target,
  output BPupdateInfo_t   info,
  output logic            ok
);

  logic [TG_HI_W-1:0] s_th;
  logic [TG_HI_W-1:0] t_th;
  logic [FT_HI_W-1:0] s_fh;
  logic [FT_HI_W-1:0] e_fh;
  logic               tgt_ok;
  logic               fall_ok;
  logic               unused_lsb;

  assign s_th = entry.startAddr[XLEN-1:FTB_TARGET_WIDTH+1];
  assign t_th = target[XLEN-1:FTB_TARGET_WIDTH+1];
  assign s_fh = entry.startAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1];
  assign e_fh = entry.endAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1];

  assign tgt_ok  = (t_th == s_th) || (t_th == s_th + TG_HI_W'(1)) || (t_th == s_th - TG_HI_W'(1));
  assign fall_ok = (e_fh == s_fh) || (e_fh == s_fh + FT_HI_W'(1));

  assign info = calcUpdateInfo(entry, taken, target);
  assign ok   = tgt_ok && fall_ok;

  // Instruction addresses are halfword aligned; bit 0 carries no information.
  assign unused_lsb = ^{target[0], entry.endAddr[0]};

endmodule

// File: rtl/ftq.sv
// Fetch target queue: BPU enqueues fetch blocks at tail, fetch consumes at
// fptr, backend commits at head and trains the FTB one cycle later.
module ftq
  import ftq_pkg::*;
#(
  parameter int FTQ_SIZE = FTQ_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pred_vld,
  output logic            o_pred_rdy,
  input  ftqInfo_t        i_pred_info,
  output logic            o_fetch_vld,
  input  logic            i_fetch_rdy,
  output ftqInfo_t        o_fetch_info,
  output ftqIdx_t         o_fetch_ftqIdx,
  input  logic            i_commit_vld,
  input  logic            i_commit_taken,
  input  logic [XLEN-1:0] i_commit_target,
  input  logic            i_squash_vld,
  input  ftqIdx_t         i_squash_ftqIdx,
  output logic            o_update_vld,
  output BPupdateInfo_t   o_update_info
);

  localparam int IW = FTQ_IDX_W;

  ftqIdx_t       head;
  ftqIdx_t       fptr;
  ftqIdx_t       tail;
  ftqIdx_t       squash_next;
  ftqInfo_t      mem [FTQ_SIZE];
  ftqInfo_t      head_entry;
  logic          full;
  logic          enq;
  logic          deq;
  logic          cmt;
  BPupdateInfo_t gen_info;
  logic          gen_ok;
  logic          vld_p1;
  BPupdateInfo_t info_p1;

  assign full        = (tail[IW-1:0] == head[IW-1:0]) && (tail[IW] != head[IW]);
  assign o_pred_rdy  = !full;
  assign o_fetch_vld = (fptr != tail);

  // Squash redirects fptr/tail, so it overrides enqueue and fetch advance.
  assign enq = i_pred_vld && o_pred_rdy && !i_squash_vld;
  assign deq = o_fetch_vld && i_fetch_rdy && !i_squash_vld;
  assign cmt = i_commit_vld && (head != fptr);

  assign squash_next    = i_squash_ftqIdx + ftqIdx_t'(1);
  assign o_fetch_info   = mem[fptr[IW-1:0]];
  assign o_fetch_ftqIdx = fptr;
  assign head_entry     = mem[head[IW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      fptr <= '0;
      tail <= '0;
    end else begin
      if (cmt) head <= head + ftqIdx_t'(1);
      if (i_squash_vld) begin
        fptr <= squash_next;
        tail <= squash_next;
      end else begin
        if (deq) fptr <= fptr + ftqIdx_t'(1);
        if (enq) tail <= tail + ftqIdx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail[IW-1:0]] <= i_pred_info;
  end

  ftq_update_gen u_update_gen (
    .entry  (head_entry),
    .taken  (i_commit_taken),
    .target (i_commit_target),
    .info   (gen_info),
    .ok     (gen_ok)
  );

  // Stage p1: registered FTB training record, valid for one cycle per commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= cmt && gen_ok;
  end

  always_ff @(posedge clk) begin
    if (cmt) info_p1 <= gen_info;
  end

  assign o_update_vld  = vld_p1;
  assign o_update_info = info_p1;

endmodule

// File: tb/tb_ftq.sv
// Randomized and directed bench for ftq against a queue model that tracks
// monotonically increasing entry numbers instead of wrapped pointers.
module tb_ftq;
  import ftq_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_pred_vld;
  logic            o_pred_rdy;
  ftqInfo_t        i_pred_info;
  logic            o_fetch_vld;
  logic            i_fetch_rdy;
  ftqInfo_t        o_fetch_info;
  ftqIdx_t         o_fetch_ftqIdx;
  logic            i_commit_vld;
  logic            i_commit_taken;
  logic [XLEN-1:0] i_commit_target;
  logic            i_squash_vld;
  ftqIdx_t         i_squash_ftqIdx;
  logic            o_update_vld;
  BPupdateInfo_t   o_update_info;

  always #5 clk = ~clk;

  ftq #(.FTQ_SIZE(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_pred_vld      (i_pred_vld),
    .o_pred_rdy      (o_pred_rdy),
    .i_pred_info     (i_pred_info),
    .o_fetch_vld     (o_fetch_vld),
    .i_fetch_rdy     (i_fetch_rdy),
    .o_fetch_info    (o_fetch_info),
    .o_fetch_ftqIdx  (o_fetch_ftqIdx),
    .i_commit_vld    (i_commit_vld),
    .i_commit_taken  (i_commit_taken),
    .i_commit_target (i_commit_target),
    .i_squash_vld    (i_squash_vld),
    .i_squash_ftqIdx (i_squash_ftqIdx),
    .o_update_vld    (o_update_vld),
    .o_update_info   (o_update_info)
  );

  int checks = 0;
  int errors = 0;

  // Model: entry numbers count up forever; slot = n % 16, wrap bit = (n / 16) % 2.
  int            m_head, m_fptr, m_tail;
  ftqInfo_t      m_mem [16];
  logic          exp_uv;
  BPupdateInfo_t exp_ui;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ftqIdx_t n2i(input int n);
    int m;
    m = n % 32;
    return ftqIdx_t'(m[4:0]);
  endfunction

  function automatic ftqInfo_t mk_info(input logic [31:0] s, input logic [31:0] e,
                                       input branch_t bt, input logic [1:0] c);
    ftqInfo_t f;
    f.startAddr = s;
    f.endAddr = e;
    f.meta.branch_type = bt;
    f.meta.ftb_counter = c;
    return f;
  endfunction

  function automatic ftqInfo_t rnd_info();
    logic [31:0] s;
    logic [31:0] len;
    s = $urandom_range(32'h0001_0000, 32'h6fff_0000) & ~32'h1;
    len = $urandom_range(2, 80) & ~32'h1;
    return mk_info(s, s + len, branch_t'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
  endfunction

  function automatic void model_update(input ftqInfo_t en, input logic tk, input logic [31:0] tg,
                                       output logic ok, output BPupdateInfo_t u);
    longint s, e, t, dt, df;
    int c;
    s = longint'(en.startAddr);
    e = longint'(en.endAddr);
    t = longint'(tg);
    dt = (t >>> 13) - (s >>> 13);
    df = (e >>> 6) - (s >>> 6);
    c = int'(en.meta.ftb_counter);
    ok = (dt >= -1) && (dt <= 1) && (df == 0 || df == 1);
    u.startAddr = en.startAddr;
    u.fallthruAddr = 5'((e >>> 1) & 31);
    u.carry = (df != 0);
    u.targetAddr = 12'((t >>> 1) & 4095);
    u.tarStat = (dt == 1) ? TAR_OVF : (dt == -1) ? TAR_UDF : TAR_FIT;
    u.branch_type = en.meta.branch_type;
    if (tk) u.counter = 2'((c == 3) ? 3 : c + 1);
    else    u.counter = 2'((c == 0) ? 0 : c - 1);
  endfunction

  // Called at a negedge: drives one cycle of inputs, checks, advances the model.
  task automatic cyc(input logic pv, input ftqInfo_t pi, input logic fr,
                     input logic cv, input logic ct, input logic [31:0] tg,
                     input logic sv, input int sq);
    logic full, enq, deq, cmt, ok;
    BPupdateInfo_t u;
    i_pred_vld = pv;
    i_pred_info = pi;
    i_fetch_rdy = fr;
    i_commit_vld = cv;
    i_commit_taken = ct;
    i_commit_target = tg;
    i_squash_vld = sv;
    i_squash_ftqIdx = n2i(sq);
    #1;
    full = (m_tail - m_head) == 16;
    check("pred_rdy", 128'(o_pred_rdy), 128'(!full));
    check("fetch_vld", 128'(o_fetch_vld), 128'(m_fptr < m_tail));
    check("fetch_idx", 128'(o_fetch_ftqIdx), 128'(n2i(m_fptr)));
    if (m_fptr < m_tail) check("fetch_info", 128'(o_fetch_info), 128'(m_mem[m_fptr % 16]));
    enq = pv && !full && !sv;
    deq = (m_fptr < m_tail) && fr && !sv;
    cmt = cv && (m_head < m_fptr);
    exp_uv = 1'b0;
    if (cmt) begin
      model_update(m_mem[m_head % 16], ct, tg, ok, u);
      exp_uv = ok;
      exp_ui = u;
      m_head++;
    end
    if (enq) m_mem[m_tail % 16] = pi;
    if (sv) begin
      m_fptr = sq + 1;
      m_tail = sq + 1;
    end else begin
      if (deq) m_fptr++;
      if (enq) m_tail++;
    end
    @(posedge clk);
    @(negedge clk);
    check("update_vld", 128'(o_update_vld), 128'(exp_uv));
    if (exp_uv) check("update_info", 128'(o_update_info), 128'(exp_ui));
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_pred_vld = 1'b0;
    i_fetch_rdy = 1'b0;
    i_commit_vld = 1'b0;
    i_squash_vld = 1'b0;
    m_head = 0;
    m_fptr = 0;
    m_tail = 0;
    exp_uv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    i_pred_vld = 1'b0;
    i_pred_info = '0;
    i_fetch_rdy = 1'b0;
    i_commit_vld = 1'b0;
    i_commit_taken = 1'b0;
    i_commit_target = '0;
    i_squash_vld = 1'b0;
    i_squash_ftqIdx = '0;
    #2;
    check("rst_pred_rdy", 128'(o_pred_rdy), 128'(1));
    check("rst_fetch_vld", 128'(o_fetch_vld), 128'(0));
    check("rst_update_vld", 128'(o_update_vld), 128'(0));
    check("rst_fetch_idx", 128'(o_fetch_ftqIdx), 128'(0));
    do_reset();

    // Fill with fetch stalled, then free one slot via fetch and commit.
    for (int i = 0; i < 16; i++) cyc(1'b1, rnd_info(), 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    check("fill_rdy_low", 128'(o_pred_rdy), 128'(0));
    cyc(1'b1, rnd_info(), 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, m_mem[0].startAddr, 1'b0, 0);
    check("fill_rdy_high", 128'(o_pred_rdy), 128'(1));
    idle();

    // Single commit with target one H-step above start.
    do_reset();
    cyc(1'b1, mk_info(32'h1000, 32'h1020, BR_COND, 2'd1), 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h1000 + 32'h2000, 1'b0, 0);
    check("ovf_vld", 128'(o_update_vld), 128'(1));
    check("ovf_stat", 128'(o_update_info.tarStat), 128'(TAR_OVF));
    check("ovf_counter", 128'(o_update_info.counter), 128'(2));
    check("ovf_carry", 128'(o_update_info.carry), 128'(0));
    idle();

    // Counter saturation, carry, out-of-range target, underflow target.
    do_reset();
    cyc(1'b1, mk_info(32'h2000, 32'h2010, BR_COND, 2'd3), 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b1, mk_info(32'h4000, 32'h4040, BR_JUMP, 2'd0), 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b1, mk_info(32'h6000, 32'h6010, BR_COND, 2'd2), 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b1, mk_info(32'h8000, 32'h8010, BR_RET, 2'd1), 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 0);
    check("sat_up", 128'(o_update_info.counter), 128'(3));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h4000, 1'b0, 0);
    check("sat_down", 128'(o_update_info.counter), 128'(0));
    check("carry_set", 128'(o_update_info.carry), 128'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h6000 + 32'h4000, 1'b0, 0);
    check("far_tgt_vld", 128'(o_update_vld), 128'(0));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h8000 - 32'h2000, 1'b0, 0);
    check("udf_start", 128'(o_update_info.startAddr), 128'(32'h8000));
    check("udf_stat", 128'(o_update_info.tarStat), 128'(TAR_UDF));
    idle();

    // Squash with a same-cycle enqueue that must be dropped.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, rnd_info(), 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b1, rnd_info(), 1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
    check("sq_fetch_idx", 128'(o_fetch_ftqIdx), 128'(2));
    check("sq_fetch_vld", 128'(o_fetch_vld), 128'(0));
    cyc(1'b1, mk_info(32'h0005_0000, 32'h0005_0010, BR_COND, 2'd2), 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    check("sq_new_start", 128'(o_fetch_info.startAddr), 128'(32'h0005_0000));
    idle();

    // Continuous enqueue/fetch/commit across several wraps.
    do_reset();
    for (int i = 0; i < 40; i++)
      cyc(1'b1, rnd_info(), 1'b1, m_head < m_fptr, 1'b1, m_mem[m_head % 16].startAddr, 1'b0, 0);
    check("wrap_idx", 128'(o_fetch_ftqIdx), 128'(n2i(39)));

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic pv, fr, cv, sv;
      int sq;
      logic [31:0] tg;
      pv = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 2) != 0);
      cv = (m_head < m_fptr) && ($urandom_range(0, 1) != 0);
      sv = (m_head < m_fptr) && ($urandom_range(0, 19) == 0);
      sq = sv ? m_head + int'($urandom_range(0, m_fptr - m_head - 1)) : 0;
      tg = (m_mem[m_head % 16].startAddr + $urandom_range(0, 5 * 8192) - 2 * 8192) & ~32'h1;
      cyc(pv, rnd_info(), fr, cv, $urandom_range(0, 1) != 0, tg, sv, sq);
    end

    // Reset mid-stream takes effect without a clock edge.
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b1, mk_info(32'h10000 + i * 32'h100, 32'h10010 + i * 32'h100, BR_COND, 2'd1),
          i >= 2, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h10000, 1'b0, 0);
    check("pre_rst_fetch_vld", 128'(o_fetch_vld), 128'(1));
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_fetch_vld", 128'(o_fetch_vld), 128'(0));
    check("mid_rst_update_vld", 128'(o_update_vld), 128'(0));
    check("mid_rst_pred_rdy", 128'(o_pred_rdy), 128'(1));
    do_reset();
    cyc(1'b1, mk_info(32'h0009_0000, 32'h0009_0020, BR_JUMP, 2'd0), 1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
